axi_time_rx_sched: RTL and testbench

Timed receive gate with a schedule queue. It sits between the ADC/PHY sample source and the DMA write FIFO. Host-side logic pushes up to QUEUE_DEPTH (start time, length) entries. For each entry the block passes exactly `length` valid samples starting at the scheduled `time_counter` value. It then reports the start timestamp and flags late entries as underruns. It extends the single-shot timed RX gate with queued back-to-back bursts, bounded burst length and a fill-level status.

---
 rtl/axi_time_rx_sched.sv | 160 ++++++++++++++++
 tb/tb_axi_time_rx_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_time_rx_sched.sv
// Timed receive gate fed by a small schedule queue of (start time, length) bursts.
// Passes exactly `length` upstream samples from each scheduled start time; flags late entries.
module axi_time_rx_sched #(
  parameter int unsigned COUNT_WIDTH = 64,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          time_enable,
  input  logic [COUNT_WIDTH-1:0]        time_counter,
  input  logic                          sched_valid,
  output logic                          sched_ready,
  input  logic [COUNT_WIDTH-1:0]        sched_time,
  input  logic [LEN_WIDTH-1:0]          sched_len,
  output logic [$clog2(QUEUE_DEPTH):0]  sched_level,
  output logic                          time_running,
  output logic                          time_underrun,
  output logic [COUNT_WIDTH-1:0]        time_capture,
  output logic                          time_capture_valid,
  input  logic                          fifo_wr_in_en,
  input  logic [DATA_WIDTH-1:0]         fifo_wr_in_data,
  input  logic                          fifo_wr_in_sync,
  output logic                          fifo_wr_in_overflow,
  output logic                          fifo_wr_in_xfer_req,
  output logic                          fifo_wr_out_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_out_data,
  output logic                          fifo_wr_out_sync,
  input  logic                          fifo_wr_out_overflow,
  input  logic                          fifo_wr_out_xfer_req
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [LVL_W-1:0]       level_q;
  logic [COUNT_WIDTH-1:0] q_time [QUEUE_DEPTH];
  logic [LEN_WIDTH-1:0]   q_len  [QUEUE_DEPTH];
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic [COUNT_WIDTH-1:0] capture_d;
  logic                   underrun_d, capture_valid_d;
  logic                   push, pop, full, data_en;
  logic [COUNT_WIDTH-1:0] head_time;
  logic [LEN_WIDTH-1:0]   head_len;

  assign full        = (level_q == LVL_W'(QUEUE_DEPTH));
  assign sched_ready = resetn & time_enable & ~full;
  assign push        = sched_valid & sched_ready;
  assign sched_level = level_q;
  assign head_time   = q_time[rd_ptr];
  assign head_len    = q_len[rd_ptr];

  // Schedule storage; contents are only meaningful below the level count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_time[wr_ptr] <= sched_time;
      q_len[wr_ptr]  <= sched_len;
    end
  end

  // Circular pointers and fill level; bypass flushes the queue.
  always_ff @(posedge clk) begin
    if (!resetn || !time_enable) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state, queue pop and status pulse generation.
  always_comb begin
    state_d         = state_q;
    pop             = 1'b0;
    underrun_d      = 1'b0;
    capture_valid_d = 1'b0;
    capture_d       = time_capture;
    remaining_d     = remaining_q;
    if (!time_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (level_q != '0) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (head_time == time_counter) begin
            capture_d = time_counter;
            if (head_len == '0) begin
              pop             = 1'b1;
              capture_valid_d = 1'b1;
              state_d         = ST_IDLE;
            end else begin
              remaining_d = head_len;
              state_d     = ST_CAPTURE;
            end
          end else if (time_counter > head_time) begin
            pop        = 1'b1;
            underrun_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          if (fifo_wr_in_en) begin
            if (remaining_q == LEN_WIDTH'(1)) begin
              pop             = 1'b1;
              capture_valid_d = 1'b1;
              state_d         = ST_IDLE;
            end else begin
              remaining_d = remaining_q - LEN_WIDTH'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      time_underrun      <= 1'b0;
      time_capture_valid <= 1'b0;
      time_capture       <= '0;
      remaining_q        <= '0;
      time_running       <= 1'b0;
    end else begin
      time_underrun      <= underrun_d;
      time_capture_valid <= capture_valid_d;
      time_capture       <= capture_d;
      remaining_q        <= remaining_d;
      time_running       <= (level_q != '0) || (state_q != ST_IDLE);
    end
  end

  // Sample gate: open in bypass or while a burst is being captured.
  assign data_en             = ~time_enable | (state_q == ST_CAPTURE);
  assign fifo_wr_out_en      = data_en & fifo_wr_in_en;
  assign fifo_wr_out_data    = data_en ? fifo_wr_in_data : '0;
  assign fifo_wr_out_sync    = data_en & fifo_wr_in_sync;
  assign fifo_wr_in_overflow = fifo_wr_out_overflow;
  assign fifo_wr_in_xfer_req = fifo_wr_out_xfer_req;

endmodule

// File: tb/tb_axi_time_rx_sched.sv
// Self-checking bench for axi_time_rx_sched: directed schedule scenarios plus a
// randomized run, all compared every cycle against a queue-based behavioural model.
module tb_axi_time_rx_sched;
  localparam int unsigned CW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned LW = 16;
  localparam int unsigned QD = 4;

  logic          clk, resetn, time_enable;
  logic [CW-1:0] time_counter, sched_time, time_capture;
  logic          sched_valid, sched_ready;
  logic [LW-1:0] sched_len;
  logic [2:0]    sched_level;
  logic          time_running, time_underrun, time_capture_valid;
  logic          in_en, in_sync, in_overflow, in_xfer;
  logic [DW-1:0] in_data, out_data;
  logic          out_en, out_sync, out_overflow, out_xfer;

  axi_time_rx_sched dut (
    .clk(clk), .resetn(resetn), .time_enable(time_enable), .time_counter(time_counter),
    .sched_valid(sched_valid), .sched_ready(sched_ready), .sched_time(sched_time),
    .sched_len(sched_len), .sched_level(sched_level), .time_running(time_running),
    .time_underrun(time_underrun), .time_capture(time_capture),
    .time_capture_valid(time_capture_valid),
    .fifo_wr_in_en(in_en), .fifo_wr_in_data(in_data), .fifo_wr_in_sync(in_sync),
    .fifo_wr_in_overflow(in_overflow), .fifo_wr_in_xfer_req(in_xfer),
    .fifo_wr_out_en(out_en), .fifo_wr_out_data(out_data), .fifo_wr_out_sync(out_sync),
    .fifo_wr_out_overflow(out_overflow), .fifo_wr_out_xfer_req(out_xfer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] t;
    logic [LW-1:0] l;
  } ent_t;

  int checks = 0;
  int errors = 0;

  // Behavioural model: pending entries, whether the head is being timed, burst progress.
  ent_t          mq[$];
  bit            m_look, m_burst, m_ur, m_capv, m_run;
  int            m_rem;
  logic [CW-1:0] m_cap;

  logic [CW-1:0] cnt, phase;
  bit            chk_en;
  int            en_mode;
  logic [CW-1:0] en_log[$], cap_log[$], ts_log[$], ur_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40)
        $display("FAIL %s: got %0h expected %0h (counter %0d)", name, act, exp, cnt);
    end
  endtask

  task automatic compare();
    bit gate;
    bit rdy;
    gate = !time_enable || m_burst;
    rdy  = resetn && time_enable && (mq.size() < QD);
    chk("out_en",   64'(out_en),   64'(gate & in_en));
    chk("out_data", out_data,      gate ? in_data : 64'd0);
    chk("out_sync", 64'(out_sync), 64'(gate & in_sync));
    chk("in_ovf",   64'(in_overflow), 64'(out_overflow));
    chk("in_xfer",  64'(in_xfer),  64'(out_xfer));
    chk("ready",    64'(sched_ready), 64'(rdy));
    chk("level",    64'(sched_level), 64'(mq.size()));
    chk("running",  64'(time_running), 64'(m_run));
    chk("underrun", 64'(time_underrun), 64'(m_ur));
    chk("cap_valid", 64'(time_capture_valid), 64'(m_capv));
    chk("capture",  time_capture, m_cap);
    if (time_enable && out_en) en_log.push_back(time_counter);
    if (time_capture_valid) begin
      cap_log.push_back(time_counter);
      ts_log.push_back(time_capture);
    end
    if (time_underrun) ur_log.push_back(time_counter);
  endtask

  task automatic model_step();
    bit   rdy, run_n, pop;
    ent_t e;
    rdy   = resetn && time_enable && (mq.size() < QD);
    run_n = (mq.size() != 0) || m_look || m_burst;
    pop   = 1'b0;
    if (!resetn) begin
      mq.delete();
      m_look = 0; m_burst = 0; m_ur = 0; m_capv = 0; m_run = 0; m_rem = 0; m_cap = '0;
    end else if (!time_enable) begin
      mq.delete();
      m_look = 0; m_burst = 0; m_ur = 0; m_capv = 0; m_run = run_n;
    end else begin
      m_ur = 0; m_capv = 0; m_run = run_n;
      if (m_burst) begin
        if (in_en) begin
          m_rem--;
          if (m_rem == 0) begin pop = 1; m_capv = 1; m_burst = 0; end
        end
      end else if (m_look) begin
        if (mq[0].t == time_counter) begin
          m_cap  = time_counter;
          m_look = 0;
          if (mq[0].l == '0) begin pop = 1; m_capv = 1; end
          else begin m_rem = int'(mq[0].l); m_burst = 1; end
        end else if (time_counter > mq[0].t) begin
          pop = 1; m_ur = 1; m_look = 0;
        end
      end else if (mq.size() != 0) begin
        m_look = 1;
      end
      if (pop) void'(mq.pop_front());
      if (sched_valid && rdy) begin
        e.t = sched_time;
        e.l = sched_len;
        mq.push_back(e);
      end
    end
  endtask

  // One clock: drive, compare at the falling edge, advance the model at the rising edge.
  task automatic step(input bit push, input logic [CW-1:0] t, input logic [LW-1:0] l);
    sched_valid  = push;
    sched_time   = t;
    sched_len    = l;
    time_counter = cnt;
    case (en_mode)
      0:       in_en = 1'b1;
      1:       in_en = ((cnt - phase) % 3 == 0);
      default: in_en = ($urandom_range(0, 9) < 7);
    endcase
    in_data      = {$urandom, $urandom};
    in_sync      = 1'($urandom);
    out_overflow = 1'($urandom);
    out_xfer     = 1'($urandom);
    @(negedge clk);
    if (chk_en) compare();
    @(posedge clk);
    model_step();
    #1;
    cnt = cnt + 1;
  endtask

  task automatic idle_until(input logic [CW-1:0] stop);
    while (cnt < stop) step(1'b0, '0, '0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    chk("rst_ready", 64'(sched_ready), 64'd0);
    resetn = 1'b1;
    en_log.delete(); cap_log.delete(); ts_log.delete(); ur_log.delete();
  endtask

  initial begin
    resetn = 1'b0; time_enable = 1'b1; sched_valid = 1'b0; sched_time = '0; sched_len = '0;
    time_counter = '0; in_en = 1'b0; in_data = '0; in_sync = 1'b0;
    out_overflow = 1'b0; out_xfer = 1'b0;
    cnt = '0; phase = '0; en_mode = 0; chk_en = 1'b0;
    m_look = 0; m_burst = 0; m_ur = 0; m_capv = 0; m_run = 0; m_rem = 0; m_cap = '0;

    step(1'b0, '0, '0);
    chk_en = 1'b1;
    do_reset();
    chk("rst_level", 64'(sched_level), 64'd0);
    chk("rst_running", 64'(time_running), 64'd0);
    chk("rst_capture", time_capture, 64'd0);
    chk("rst_capv", 64'(time_capture_valid), 64'd0);
    chk("rst_underrun", 64'(time_underrun), 64'd0);

    // Single burst t=100 len=4, samples every cycle.
    cnt = 90;
    step(1'b1, 64'd100, 16'd4);
    idle_until(110);
    chk("d1_en_n", 64'(en_log.size()), 64'd4);
    chk("d1_en_first", en_log[0], 64'd101);
    chk("d1_en_last", en_log[3], 64'd104);
    chk("d1_cap_n", 64'(cap_log.size()), 64'd1);
    chk("d1_cap_at", cap_log[0], 64'd105);
    chk("d1_cap_ts", ts_log[0], 64'd100);

    // Four back-to-back entries fill the queue.
    do_reset();
    cnt = 190;
    step(1'b1, 64'd200, 16'd8);
    step(1'b1, 64'd220, 16'd8);
    step(1'b1, 64'd240, 16'd2);
    step(1'b1, 64'd260, 16'd0);
    chk("d2_full_level", 64'(sched_level), 64'd4);
    chk("d2_full_ready", 64'(sched_ready), 64'd0);
    idle_until(270);
    chk("d2_cap_n", 64'(cap_log.size()), 64'd4);
    chk("d2_cap0", cap_log[0], 64'd209);
    chk("d2_cap1", cap_log[1], 64'd229);
    chk("d2_cap2", cap_log[2], 64'd243);
    chk("d2_cap3", cap_log[3], 64'd261);
    chk("d2_ts0", ts_log[0], 64'd200);
    chk("d2_ts1", ts_log[1], 64'd220);
    chk("d2_ts2", ts_log[2], 64'd240);
    chk("d2_ts3", ts_log[3], 64'd260);
    chk("d2_en_n", 64'(en_log.size()), 64'd18);
    chk("d2_en_last", en_log[17], 64'd242);

    // Late entry underruns; the following entry is still serviced.
    do_reset();
    cnt = 80;
    step(1'b1, 64'd50, 16'd4);
    step(1'b1, 64'd95, 16'd2);
    idle_until(110);
    chk("d3_ur_n", 64'(ur_log.size()), 64'd1);
    chk("d3_ur_at", ur_log[0], 64'd83);
    chk("d3_en_n", 64'(en_log.size()), 64'd2);
    chk("d3_en_first", en_log[0], 64'd96);
    chk("d3_cap_n", 64'(cap_log.size()), 64'd1);
    chk("d3_cap_at", cap_log[0], 64'd98);
    chk("d3_cap_ts", ts_log[0], 64'd95);

    // Sparse samples, one every third cycle.
    do_reset();
    cnt = 290; phase = 301; en_mode = 1;
    step(1'b1, 64'd300, 16'd3);
    idle_until(315);
    chk("d4_en_n", 64'(en_log.size()), 64'd3);
    chk("d4_en0", en_log[0], 64'd301);
    chk("d4_en1", en_log[1], 64'd304);
    chk("d4_en2", en_log[2], 64'd307);
    chk("d4_cap_n", 64'(cap_log.size()), 64'd1);
    chk("d4_cap_at", cap_log[0], 64'd308);
    en_mode = 0;

    // Bypass mid-burst, then re-enable with an empty queue.
    do_reset();
    cnt = 390;
    step(1'b1, 64'd400, 16'd8);
    idle_until(403);
    time_enable = 1'b0;
    idle_until(407);
    chk("d5_level", 64'(sched_level), 64'd0);
    time_enable = 1'b1;
    idle_until(420);
    chk("d5_en_n", 64'(en_log.size()), 64'd2);
    chk("d5_cap_n", 64'(cap_log.size()), 64'd0);
    chk("d5_running", 64'(time_running), 64'd0);

    // Reset during a burst with further entries queued.
    do_reset();
    cnt = 490;
    step(1'b1, 64'd500, 16'd8);
    step(1'b1, 64'd520, 16'd4);
    step(1'b1, 64'd540, 16'd4);
    idle_until(503);
    resetn = 1'b0;
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    resetn = 1'b1;
    chk("d6_level", 64'(sched_level), 64'd0);
    chk("d6_running", 64'(time_running), 64'd0);
    chk("d6_capture", time_capture, 64'd0);
    idle_until(560);
    chk("d6_en_n", 64'(en_log.size()), 64'd3);
    chk("d6_en_last", en_log[2], 64'd503);
    chk("d6_cap_n", 64'(cap_log.size()), 64'd0);
    chk("d6_ur_n", 64'(ur_log.size()), 64'd0);

    // Randomized schedule, sample, bypass and reset activity.
    do_reset();
    cnt = 1000; en_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if (time_enable) time_enable = ($urandom_range(0, 99) >= 2);
      else             time_enable = ($urandom_range(0, 99) < 30);
      resetn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 19) == 0) cnt = cnt + 64'($urandom_range(1, 3));
      if ($urandom_range(0, 9) < 3)
        step(1'b1, cnt + 64'($urandom_range(0, 25)), 16'($urandom_range(0, 5)));
      else
        step(1'b0, '0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
